approx_err_accum: RTL

- Downstream evaluation stage for the 8x8 approximate multipliers. It consumes operand pairs (a, b) and the approximate 16-bit product they produced.
- Recomputes the exact product internally and accumulates error metrics over a fixed-length run of N_SAMPLES samples: sum of error distance (ED), maximum ED with its operands, and erroneous-result count.
- Used on-chip to characterise approximate multiplier variants exhaustively or over streamed test vectors.

---
 rtl/approx_err_accum.sv | 114 +++++++++++
 1 files changed

// File: rtl/approx_err_accum.sv
// Error-metric accumulator for approximate multipliers: compares each approximate
// product against the exact one and collects ED sum/max/count over a run.
module approx_err_accum #(
  parameter int WIDTH     = 8,
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int SUM_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   prod_apx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [SUM_W-1:0]     sum_ed,
  output logic [2*WIDTH-1:0]   max_ed,
  output logic [WIDTH-1:0]     max_a,
  output logic [WIDTH-1:0]     max_b
);
  localparam int PW = 2 * WIDTH;
  localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] acc_cnt;
  logic [1:0]       vld_pipe;  // [0] accept this cycle, [1] stage-1 holds a sample
  logic             clr;
  logic             last_accept;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [PW-1:0]    s1_exact, s1_apx, ed;
  logic [AW-1:0]    sum_full;

  assign in_ready    = (state == RUN);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign vld_pipe[0] = in_valid && in_ready;
  assign last_accept = vld_pipe[0] && (acc_cnt == CNT_W'(N_SAMPLES - 1));

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        clr      = 1'b1;
        state_nx = RUN;
      end
      RUN:     if (last_accept) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign ed       = (s1_exact >= s1_apx) ? (s1_exact - s1_apx) : (s1_apx - s1_exact);
  assign sum_full = AW'(sum_ed) + AW'(ed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      acc_cnt     <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_exact    <= '0;
      s1_apx      <= '0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_ed      <= '0;
      max_ed      <= '0;
      max_a       <= '0;
      max_b       <= '0;
    end else if (clr) begin
      vld_pipe[1] <= 1'b0;
      acc_cnt     <= '0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_ed      <= '0;
      max_ed      <= '0;
      max_a       <= '0;
      max_b       <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        acc_cnt  <= acc_cnt + 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_exact <= PW'(a) * PW'(b);
        s1_apx   <= prod_apx;
      end
      if (vld_pipe[1]) begin
        sample_cnt <= sample_cnt + 1'b1;
        if (ed != '0) err_cnt <= err_cnt + 1'b1;
        // Clamp instead of wrapping so a long run still reports a lower bound.
        if (sum_full > AW'({SUM_W{1'b1}})) sum_ed <= '1;
        else                               sum_ed <= sum_full[SUM_W-1:0];
        if (ed > max_ed) begin
          max_ed <= ed;
          max_a  <= s1_a;
          max_b  <= s1_b;
        end
      end
    end
  end
endmodule
